// File: rtl/ubcd_pkg.sv
// rtl/ubcd_pkg.sv - shared types and constants for the multiplexed ASCII digit scanner
// Contents: scan FSM state enum, blank-character constant.
package ubcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } ubcd_state_e;

  localparam logic [6:0] UBCD_SPACE = 7'h20;

endpackage

// File: rtl/ubcd_tick_gen.sv
// rtl/ubcd_tick_gen.sv - loadable down-counter timing the BLANK and SHOW dwell periods
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load counter with load_val this edge (overrides counting)
//   load_val    value loaded; a dwell of D cycles is loaded as D-1
//   expired     counter is zero (last cycle of the current dwell)
module ubcd_tick_gen #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ubcd_scan_ctrl.sv
// rtl/ubcd_scan_ctrl.sv - digit scan controller feeding a shared ASCII segment decoder
// Optional feature macro: UBCD_SCROLL_EN (buffer rotates left every SCROLL_FRAMES frames).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              scanning runs while high
//   wr_valid/wr_ready   character write handshake; wr_addr selects digit, wr_char is ASCII
//   clr                 one-cycle pulse filling the buffer with spaces
//   scroll_en           scroll request (only meaningful with UBCD_SCROLL_EN)
//   dec_char            registered character for the shared decoder
//   dig_en              one-hot digit enable, all zero while blanking/idle
//   frame_tick          one-cycle pulse in the last cycle of the last digit's SHOW
module ubcd_scan_ctrl
  import ubcd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE      = 1024,
  parameter int BLANK_CYCLES  = 16,
  parameter int SCROLL_FRAMES = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [6:0]                    wr_char,
  input  logic                          clr,
  input  logic                          scroll_en,
  output logic [6:0]                    dec_char,
  output logic [NUM_DIGITS-1:0]         dig_en,
  output logic                          frame_tick
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int DMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(DMAX + 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LD  = CW'(PRESCALE - 1);

  ubcd_state_e   state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [6:0]    char_buf [NUM_DIGITS];
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_exp;
  logic          latch_char;
  logic          advance;
  logic          last_digit;
  logic          wr_fire;

  ubcd_tick_gen #(.W(CW)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expired  (cnt_exp)
  );

  assign last_digit = (idx_q == IW'(NUM_DIGITS - 1));
  assign wr_ready   = ~clr;
  // Out-of-range addresses complete the handshake but store nothing.
  assign wr_fire    = wr_valid & ~clr & (int'(wr_addr) < NUM_DIGITS);
  assign frame_tick = advance & last_digit;
  assign dig_en     = (state_q == SHOW) ? (NUM_DIGITS'(1) << idx_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter is reloaded on every state entry so each dwell is exact.
  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    latch_char = 1'b0;
    advance    = 1'b0;
    if (!enable) begin
      state_d  = IDLE;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          cnt_load = 1'b1;
          cnt_val  = BLANK_LD;
        end
        BLANK: begin
          if (cnt_exp) begin
            state_d    = SHOW;
            cnt_load   = 1'b1;
            cnt_val    = SHOW_LD;
            latch_char = 1'b1;
          end
        end
        SHOW: begin
          if (cnt_exp) begin
            state_d  = BLANK;
            cnt_load = 1'b1;
            cnt_val  = BLANK_LD;
            advance  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // dec_char is sampled only at SHOW entry, so buffer writes never change a digit mid-SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      dec_char <= UBCD_SPACE;
    end else begin
      if (!enable) begin
        idx_q <= '0;
      end else if (advance) begin
        idx_q <= last_digit ? '0 : idx_q + 1'b1;
      end
      if (latch_char) begin
        dec_char <= char_buf[idx_q];
      end
    end
  end

`ifdef UBCD_SCROLL_EN
  localparam int FW = $clog2(SCROLL_FRAMES + 1);
  logic [FW-1:0] fcnt_q;
  logic          rotate;

  assign rotate = frame_tick & scroll_en & (fcnt_q == FW'(SCROLL_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else if (!scroll_en) begin
      fcnt_q <= '0;
    end else if (frame_tick) begin
      fcnt_q <= rotate ? '0 : fcnt_q + 1'b1;
    end
  end
`else
  logic unused_scroll;
  assign unused_scroll = &{1'b0, scroll_en, SCROLL_FRAMES[0]};
`endif

  // Priority: clr, then write, then rotation (later assignment wins for the written slot).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) char_buf[i] <= UBCD_SPACE;
    end else if (clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) char_buf[i] <= UBCD_SPACE;
    end else begin
`ifdef UBCD_SCROLL_EN
      if (rotate) begin
        for (int i = 0; i < NUM_DIGITS; i++) char_buf[i] <= char_buf[IW'((i + 1) % NUM_DIGITS)];
      end
`endif
      if (wr_fire) begin
        char_buf[wr_addr] <= wr_char;
      end
    end
  end

endmodule
